// File: rtl/apb_master_pkg.sv
// Shared APB definitions: FSM state encoding, idle select code, default bus
// widths and the wait-counter width helper.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  localparam logic [1:0] SEL_NONE = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_ACCESS   = 2'd2,
    ST_RESP_ERR = 2'd3
  } apb_state_e;

  // Bits needed to count 0..timeout, never less than one.
  function automatic int timer_width(input int timeout);
    int w;
    if (timeout > 0) begin
      w = $clog2(timeout + 1);
    end else begin
      w = 1;
    end
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// Request/response port and APB bus of the master, bundled as one interface.
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_id;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [1:0]        apb_sel;
  logic              apb_enable;
  logic              apb_write;
  logic [ADDR_W-1:0] apb_addr;
  logic [DATA_W-1:0] apb_wdata;
  logic [DATA_W-1:0] apb_rdata;
  logic              apb_ready;

  modport master (
    input  req_valid, req_id, req_write, req_addr, req_wdata, apb_rdata, apb_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           apb_sel, apb_enable, apb_write, apb_addr, apb_wdata
  );

  modport slave (
    output req_valid, req_id, req_write, req_addr, req_wdata, apb_rdata, apb_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           apb_sel, apb_enable, apb_write, apb_addr, apb_wdata
  );

endinterface

// File: rtl/apb_master_wait_timer.sv
// Counts ACCESS cycles spent waiting on the slave and flags the last allowed
// one. TIMEOUT of 0 means the flag never fires.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = timer_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear outside ACCESS, step on every wait edge.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (TIMEOUT > 0) && en_i && (count_q == LAST);

endmodule

// File: rtl/apb_master.sv
// APB initiator: takes one command at a time, runs SETUP/ACCESS toward the
// selected slave with a bounded wait and returns a single response pulse.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  apb_master_if.master bus
);

  apb_state_e        state_q, state_d;
  logic              live_q;
  logic [1:0]        sel_q, sel_d;
  logic              enable_q, enable_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic req_ready_s;
  logic accept_s;
  logic expired_s;

  // live_q keeps req_ready low until the first edge after reset release.
  assign req_ready_s = live_q && (state_q == ST_IDLE);
  assign accept_s    = req_ready_s && bus.req_valid;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (state_q != ST_ACCESS),
    .en_i      ((state_q == ST_ACCESS) && !bus.apb_ready),
    .expired_o (expired_s)
  );

  // Next state and next registered outputs; bus fields hold unless a legal
  // command is accepted, response fields hold after the pulse.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    enable_d    = enable_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (bus.req_id != SEL_NONE)) begin
          state_d = ST_SETUP;
          sel_d   = bus.req_id;
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
        end else if (accept_s) begin
          state_d = ST_RESP_ERR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d  = ST_ACCESS;
        enable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (bus.apb_ready) begin
          state_d     = ST_IDLE;
          sel_d       = SEL_NONE;
          enable_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = write_q ? '0 : bus.apb_rdata;
        end else if (expired_s) begin
          state_d     = ST_IDLE;
          sel_d       = SEL_NONE;
          enable_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_RESP_ERR: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
      end
      default: begin
        state_d  = ST_IDLE;
        sel_d    = SEL_NONE;
        enable_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      live_q      <= 1'b0;
      sel_q       <= SEL_NONE;
      enable_q    <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      live_q      <= 1'b1;
      sel_q       <= sel_d;
      enable_q    <= enable_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.apb_sel    = sel_q;
  assign bus.apb_enable = enable_q;
  assign bus.apb_write  = write_q;
  assign bus.apb_addr   = addr_q;
  assign bus.apb_wdata  = wdata_q;

endmodule
